morse_key_sequencer: RTL and testbench

- Controller that turns one Morse character per handshake into correctly timed KEY on/off intervals.
- All durations are counted in dit units. One unit is one TICK pulse: a single-FAST-cycle strobe from the slow-to-fast clock edge synchroniser.
- Sits between the character source (text/lookup logic) and the tone/LED driver.
- Runs entirely in the FAST domain.

---
 rtl/morse_key_sequencer.sv | 161 ++++++++++++++++
 tb/tb_morse_key_sequencer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/morse_key_sequencer.sv
// Morse key sequencer: turns one character per valid/ready handshake into KEY on/off
// intervals measured in TICK units (dot = 1, dash = DASH_UNITS, gaps as parameterised).
// Optional macro MORSE_FARNSWORTH_EN adds a gap_stretch input that lengthens char/word gaps.
module morse_key_sequencer #(
  parameter int unsigned MAX_ELEMS      = 6,
  parameter int unsigned DASH_UNITS     = 3,
  parameter int unsigned CHAR_GAP_UNITS = 3,
  parameter int unsigned WORD_GAP_UNITS = 7,
  parameter int unsigned CNT_W          = 4
) (
  input  logic                               fast,
  input  logic                               reset,
  input  logic                               tick,
  input  logic                               char_valid,
  output logic                               char_ready,
  input  logic [$clog2(MAX_ELEMS+1)-1:0]     char_len,
  input  logic [MAX_ELEMS-1:0]               char_bits,
`ifdef MORSE_FARNSWORTH_EN
  input  logic [3:0]                         gap_stretch,
`endif
  output logic                               key,
  output logic                               busy,
  output logic                               done
);

  localparam int unsigned LEN_W = $clog2(MAX_ELEMS + 1);

  typedef enum logic [2:0] {StIdle, StMark, StElemGap, StCharGap, StWordGap} state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [LEN_W-1:0]     idx_q, idx_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [MAX_ELEMS-1:0] bits_q, bits_d;
  logic                 key_q, key_d;
  logic                 done_q, done_d;

  logic [3:0]           stretch_q;
  logic [3:0]           stretch_in;

`ifdef MORSE_FARNSWORTH_EN
  assign stretch_in = gap_stretch;

  // Stretch is captured with the character so gap timing cannot change mid-character.
  always_ff @(posedge fast or posedge reset) begin
    if (reset) begin
      stretch_q <= '0;
    end else if (char_valid && char_ready) begin
      stretch_q <= gap_stretch;
    end
  end
`else
  assign stretch_in = '0;
  assign stretch_q  = '0;
`endif

  logic [LEN_W-1:0]     len_in;
  logic [LEN_W-1:0]     idx_nxt;
  logic [MAX_ELEMS-1:0] bits_shift;
  logic                 expire;

  assign len_in     = (char_len > LEN_W'(MAX_ELEMS)) ? LEN_W'(MAX_ELEMS) : char_len;
  assign idx_nxt    = idx_q + LEN_W'(1);
  assign bits_shift = bits_q >> idx_nxt;
  // The interval ends on the counted TICK that takes the counter from 1 to 0.
  assign expire     = tick && (cnt_q <= CNT_W'(1));

  assign char_ready = (state_q == StIdle);
  assign busy       = (state_q != StIdle);
  assign key        = key_q;
  assign done       = done_q;

  // Next-state, counter reloads and registered KEY/DONE values.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    len_d   = len_q;
    bits_d  = bits_q;
    key_d   = key_q;
    done_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (char_valid) begin
          len_d  = len_in;
          bits_d = char_bits;
          idx_d  = '0;
          if (len_in != '0) begin
            state_d = StMark;
            key_d   = 1'b1;
            cnt_d   = char_bits[0] ? CNT_W'(DASH_UNITS) : CNT_W'(1);
          end else begin
            state_d = StWordGap;
            key_d   = 1'b0;
            cnt_d   = CNT_W'(WORD_GAP_UNITS - CHAR_GAP_UNITS) + CNT_W'(stretch_in);
          end
        end
      end
      StMark: begin
        if (expire) begin
          key_d = 1'b0;
          if (idx_nxt < len_q) begin
            state_d = StElemGap;
            cnt_d   = CNT_W'(1);
          end else begin
            state_d = StCharGap;
            cnt_d   = CNT_W'(CHAR_GAP_UNITS) + CNT_W'(stretch_q);
          end
        end else if (tick) begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      StElemGap: begin
        if (expire) begin
          state_d = StMark;
          idx_d   = idx_nxt;
          key_d   = 1'b1;
          cnt_d   = bits_shift[0] ? CNT_W'(DASH_UNITS) : CNT_W'(1);
        end else if (tick) begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      StCharGap, StWordGap: begin
        if (expire) begin
          state_d = StIdle;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else if (tick) begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = StIdle;
        key_d   = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  // State and datapath registers; reset drops KEY immediately and discards the character.
  always_ff @(posedge fast or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      bits_q  <= '0;
      key_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      bits_q  <= bits_d;
      key_q   <= key_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_morse_key_sequencer.sv
// Scoreboard bench for morse_key_sequencer: each offered character pushes the expected
// KEY pattern (KEY sampled at every counted TICK, '1'/'0') and a monitor compares on DONE.
module tb_morse_key_sequencer;

  logic       fast = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       char_valid = 1'b0;
  logic       char_ready;
  logic [2:0] char_len = '0;
  logic [5:0] char_bits = '0;
  logic [3:0] gap_stretch = '0;
  logic       key, busy, done;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  int acc_in_done = 0;
  int pushed = 0;

  string exp_q[$];
  string name_q[$];
  string pattern = "";
  bit    busy_ok = 1'b1;
  bit    in_char = 1'b0;
  bit    done_prev = 1'b0;

  morse_key_sequencer dut (
    .fast       (fast),
    .reset      (reset),
    .tick       (tick),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .char_len   (char_len),
    .char_bits  (char_bits),
`ifdef MORSE_FARNSWORTH_EN
    .gap_stretch(gap_stretch),
`endif
    .key        (key),
    .busy       (busy),
    .done       (done)
  );

  always #5 fast = ~fast;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: scores each completed character against the head of the scoreboard.
  always @(negedge fast) begin
    if (!reset) begin
      if (done) begin
        done_cnt++;
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_done: got DONE pulse, expected none");
        end else begin
          string e, n;
          e = exp_q.pop_front();
          n = name_q.pop_front();
          if (pattern != e || !busy_ok || done_prev || key || !char_ready) begin
            fails++;
            $display("FAIL %s: got pattern=%s busy_ok=%0d done_prev=%0d key=%0d ready=%0d, expected pattern=%s busy_ok=1 done_prev=0 key=0 ready=1",
                     n, pattern, busy_ok, done_prev, key, char_ready, e);
          end
        end
        in_char = 1'b0;
      end
      if (char_valid && char_ready) begin
        pattern = "";
        busy_ok = 1'b1;
        in_char = 1'b1;
        if (done) acc_in_done++;
      end else if (in_char && !done) begin
        if (!busy) busy_ok = 1'b0;
        if (tick) begin
          if (key) pattern = {pattern, "1"};
          else     pattern = {pattern, "0"};
        end
      end
      done_prev = done;
    end
  end

  // One FAST cycle with the given TICK value; drops VALID once it has been accepted.
  task automatic cyc(input logic t);
    logic acc;
    tick = t;
    @(negedge fast);
    acc = char_valid && char_ready;
    @(posedge fast);
    #1;
    tick = 1'b0;
    if (acc) char_valid = 1'b0;
  endtask

  task automatic units(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1'b0); cyc(1'b0); cyc(1'b0); cyc(1'b1);
    end
  endtask

  task automatic offer(input logic [2:0] len, input logic [5:0] bits, input string name,
                       input string exp, input bit expect_done);
    char_len   = len;
    char_bits  = bits;
    char_valid = 1'b1;
    if (expect_done) begin
      exp_q.push_back(exp);
      name_q.push_back(name);
      pushed++;
    end
  endtask

  task automatic run_until_done(input int target, input int max_units, input string name);
    int u = 0;
    while (done_cnt < target && u < max_units) begin
      units(1);
      u++;
    end
    check({name, "_timeout"}, int'(done_cnt >= target), 1);
  endtask

  initial begin
    int idle_bad;
    int dc;

    repeat (3) @(posedge fast);
    check("rst_key", key, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", char_ready, 1);
    check("rst_done", done, 0);
    #1 reset = 1'b0;

    // Idle ticks must not disturb anything.
    idle_bad = 0;
    for (int i = 0; i < 20; i++) begin
      units(1);
      if (key || busy || done || !char_ready) idle_bad++;
    end
    check("idle_ticks", idle_bad, 0);

    // 'A' = dot dash.
    offer(3'd2, 6'b000010, "char_A", "10111000", 1'b1);
    run_until_done(1, 14, "char_A");

    // Word space, with 'E' held valid so it is taken in the DONE cycle.
    offer(3'd0, 6'b000000, "word_space", "0000", 1'b1);
    cyc(1'b0);
    offer(3'd1, 6'b000000, "char_E_b2b", "1000", 1'b1);
    run_until_done(3, 16, "space_E");
    check("accept_in_done", acc_in_done, 1);

    // LEN=7 clamps to six dashes.
    offer(3'd7, 6'b111111, "clamp_len7",
          "11101110111011101110111000", 1'b1);
    run_until_done(4, 34, "clamp_len7");

    // TICK in the transfer cycle is not counted.
    offer(3'd1, 6'b000001, "char_T_tick_on_xfer", "111000", 1'b1);
    cyc(1'b1);
    run_until_done(5, 10, "char_T");

    // Reset in the middle of the second dash of 'M'.
    dc = done_cnt;
    offer(3'd2, 6'b000011, "char_M", "", 1'b0);
    units(5);
    check("m_key_before_rst", key, 1);
    #2 reset = 1'b1;
    #1;
    check("m_rst_key", key, 0);
    check("m_rst_busy", busy, 0);
    check("m_rst_ready", char_ready, 1);
    reset = 1'b0;
    units(6);
    check("m_no_done", done_cnt, dc);

    offer(3'd1, 6'b000000, "char_E_after_rst", "1000", 1'b1);
    run_until_done(6, 10, "char_E_after_rst");

`ifdef MORSE_FARNSWORTH_EN
    gap_stretch = 4'd2;
    offer(3'd1, 6'b000000, "char_E_stretch2", "100000", 1'b1);
    run_until_done(7, 12, "char_E_stretch2");
    gap_stretch = 4'd0;
`endif

    units(3);
    check("scoreboard_empty", exp_q.size(), 0);
    check("done_count", done_cnt, pushed);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Absolute watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish before 200000");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
